// File: rtl/perf_overflow_ctrl.sv
// perf_overflow_ctrl: sticky overflow (OF) bits for the generic HPM counters
// mhpmcounter3.. and the local-counter-overflow interrupt (LCOFI) request.
// Supplies the OF field of mhpmevent3..8 (or mhpmevent3h..8h on RV32) and the
// scountovf CSR as read data that csr_regfile ORs with the counter read data.
module perf_overflow_ctrl #(
    parameter int unsigned NumCounters  = 6,
    parameter int unsigned CounterWidth = 64,
    parameter int unsigned XLEN         = 64
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic                                       debug_mode_i,
    input  logic [1:0]                                 priv_lvl_i,
    input  logic [31:0]                                mcounteren_i,
    input  logic [11:0]                                addr_i,
    input  logic                                       we_i,
    input  logic [XLEN-1:0]                            data_i,
    output logic [XLEN-1:0]                            data_o,
    input  logic [NumCounters-1:0][CounterWidth-1:0]   count_i,
    input  logic [NumCounters-1:0]                     incr_i,
    input  logic                                       lcofi_clr_i,
    output logic [NumCounters-1:0]                     of_o,
    output logic                                       lcofi_o
);

    // Privilege encodings (riscv::priv_lvl_t).
    localparam logic [1:0] PrivM = 2'b11;
    localparam logic [1:0] PrivS = 2'b01;

    // OF lives in the top bit of mhpmevent on RV64 and of mhpmeventh on RV32,
    // so the owning CSR address and the bit position both follow XLEN.
    localparam logic [11:0] OfAddrBase   = (XLEN == 64) ? 12'h323 : 12'h723;
    localparam logic [11:0] ScountovfAddr = 12'hDA0;

    logic [NumCounters-1:0] of_q;
    logic [NumCounters-1:0] of_d;
    logic [NumCounters-1:0] ovf;
    logic                   lcofi_set;
    logic                   lcofip_q;

    // Overflow detection and next OF value; a software write beats hardware.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        ovf  = '0;
        of_d = of_q;
        for (int i = 0; i < int'(NumCounters); i++) begin
            // Only the exact all-ones -> zero wrap counts as an overflow.
            ovf[i] = incr_i[i] && (count_i[i] == {CounterWidth{1'b1}}) && !debug_mode_i;
            if (we_i && (addr_i == OfAddrBase + 12'(i))) begin
                of_d[i] = data_i[XLEN-1];
            end else if (ovf[i]) begin
                of_d[i] = 1'b1;
            end
        end
        // Only a hardware 0->1 transition of OF raises the interrupt.
        lcofi_set = |(ovf & ~of_q);
    end

    // OF and LCOFI pending state; a new set wins over a same-cycle clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            of_q     <= '0;
            lcofip_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            of_q     <= of_d;
            lcofip_q <= lcofi_set | (lcofip_q & ~lcofi_clr_i);
        end
    end

    // CSR read contribution: OF bit of mhpmevent(h) or the scountovf view.
    always_comb begin
        data_o = '0;
        for (int i = 0; i < int'(NumCounters); i++) begin
            if (addr_i == OfAddrBase + 12'(i)) begin
                data_o[XLEN-1] = of_q[i];
            end
        end
        if (addr_i == ScountovfAddr) begin
            if (priv_lvl_i == PrivM) begin
                data_o[NumCounters+2:3] = of_q;
            end else if (priv_lvl_i == PrivS) begin
                data_o[NumCounters+2:3] = of_q & mcounteren_i[NumCounters+2:3];
            end
        end
    end

    assign of_o    = of_q;
    assign lcofi_o = lcofip_q;

    // Bits of the CSR buses that carry nothing for this block.
    logic unused_bits;
    assign unused_bits = ^{mcounteren_i, data_i[XLEN-2:0]};

endmodule
